// File: rtl/counter_4bit_if.sv
// Output bundle of the modulo counter. The counter drives it through the
// master modport; anything using the timebase reads it through slave.
interface counter_4bit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_gray;
    logic             tc;
    logic             wrapped;

    modport master (
        output count,
        output count_gray,
        output tc,
        output wrapped
    );

    modport slave (
        input count,
        input count_gray,
        input tc,
        input wrapped
    );
endinterface

// File: rtl/counter_4bit.sv
// Free-running modulo counter used as a timebase. Produces a registered
// count, its Gray-coded copy, a terminal-count strobe that flags the edge
// about to wrap, and a sticky flag that stays set once the first wrap has
// happened. Up or down, with any step below the modulus.
module counter_4bit #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = longint'(1) << WIDTH,
    parameter longint STEP    = 1,
    parameter bit     DOWN    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    counter_4bit_if.master     bus
);

    // Illegal parameter combinations stop elaboration with a message.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("counter_4bit: WIDTH=%0d is outside 1..32", WIDTH);
        end
        if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("counter_4bit: MODULUS=%0d is outside 2..2**WIDTH (WIDTH=%0d)",
                   MODULUS, WIDTH);
        end
        if (STEP < 1 || STEP >= MODULUS) begin : g_bad_step
            $error("counter_4bit: STEP=%0d is outside 1..MODULUS-1 (MODULUS=%0d)",
                   STEP, MODULUS);
        end
    endgenerate

    // One extra bit so count+STEP and count+MODULUS never overflow.
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] RST_VAL = DOWN ? WIDTH'(MODULUS - 1) : '0;

    logic [WIDTH-1:0] count_q;
    logic             wrapped_q;
    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   next_x;
    logic             tc;

    // Next-state and wrap detection; tc is the "this edge wraps" condition.
    always_comb begin
        count_x = {1'b0, count_q};
        next_x  = '0;
        tc      = 1'b0;
        if (DOWN) begin
            tc = (count_x < STEP_X);
            if (tc) begin
                next_x = count_x + (MOD_X - STEP_X);
            end else begin
                next_x = count_x - STEP_X;
            end
        end else begin
            next_x = count_x + STEP_X;
            tc     = (next_x >= MOD_X);
            if (tc) begin
                next_x = next_x - MOD_X;
            end
        end
    end

    // Count register and sticky wrap flag; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= RST_VAL;
            wrapped_q <= 1'b0;
        end else begin
            count_q <= WIDTH'(next_x);
            if (tc) begin
                wrapped_q <= 1'b1;
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.count_gray = count_q ^ (count_q >> 1);
    assign bus.tc         = tc;
    assign bus.wrapped    = wrapped_q;

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit: default up counter, a MODULUS=10/STEP=3
// variant and a DOWN=1 variant all run side by side from one clock and reset.
module tb_counter_4bit;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    logic [3:0] m10_tab [10]  = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7};
    logic [3:0] prev_gray;

    counter_4bit_if #(.WIDTH(4)) bus_def ();
    counter_4bit_if #(.WIDTH(4)) bus_m10 ();
    counter_4bit_if #(.WIDTH(4)) bus_dn ();

    counter_4bit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_def)
    );

    counter_4bit #(.WIDTH(4), .MODULUS(10), .STEP(3)) u_dut_m10 (
        .clk (clk),
        .rst (rst),
        .bus (bus_m10)
    );

    counter_4bit #(.WIDTH(4), .MODULUS(16), .STEP(1), .DOWN(1'b1)) u_dut_dn (
        .clk (clk),
        .rst (rst),
        .bus (bus_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // k = rising edges since rst was last released (0 = reset value).
    task automatic check_all(input int k);
        logic [3:0] d_cnt;
        logic [3:0] m_cnt;
        logic [3:0] n_cnt;
        d_cnt = 4'(k % 16);
        m_cnt = m10_tab[k % 10];
        n_cnt = 4'(15 - (k % 16));

        check_eq($sformatf("def_count k=%0d", k),   32'(bus_def.count),      32'(d_cnt));
        check_eq($sformatf("def_gray k=%0d", k),    32'(bus_def.count_gray), 32'(gray_tab[d_cnt]));
        check_eq($sformatf("def_tc k=%0d", k),      32'(bus_def.tc),         32'(d_cnt == 4'd15));
        check_eq($sformatf("def_wrapped k=%0d", k), 32'(bus_def.wrapped),    32'(k >= 16));
        if (k > 0) begin
            check_eq($sformatf("def_gray_1bit k=%0d", k),
                     32'($countones(bus_def.count_gray ^ prev_gray)), 32'd1);
        end
        prev_gray = bus_def.count_gray;

        check_eq($sformatf("m10_count k=%0d", k),   32'(bus_m10.count),      32'(m_cnt));
        check_eq($sformatf("m10_tc k=%0d", k),      32'(bus_m10.tc),         32'(m_cnt >= 4'd7));
        check_eq($sformatf("m10_wrapped k=%0d", k), 32'(bus_m10.wrapped),    32'(k >= 4));

        check_eq($sformatf("dn_count k=%0d", k),    32'(bus_dn.count),       32'(n_cnt));
        check_eq($sformatf("dn_tc k=%0d", k),       32'(bus_dn.tc),          32'(n_cnt == 4'd0));
        check_eq($sformatf("dn_wrapped k=%0d", k),  32'(bus_dn.wrapped),     32'(k >= 16));
    endtask

    task automatic run_edges(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_all(k);
        end
    endtask

    initial begin
        rst       = 1'b1;
        prev_gray = '0;

        // Reset held for three edges: outputs sit at reset values each time.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_all(0);
        end

        rst = 1'b0;
        // Through the first wrap of every variant; stops with default count=9.
        run_edges(25);
        check_eq("pre_reset_count", 32'(bus_def.count), 32'd9);
        check_eq("pre_reset_wrapped", 32'(bus_def.wrapped), 32'd1);

        // Single-edge reset in the middle of a count.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all(0);
        rst = 1'b0;

        // Counting resumes from the reset value, through another full wrap
        // and 20 further edges of sticky wrapped.
        run_edges(36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
